// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: state encodings and the
// default timeout / stability tolerance.
package clock_period_meter_pkg;

    localparam logic [1:0] IDLE_CODE = 2'd0;
    localparam logic [1:0] ARM_CODE  = 2'd1;
    localparam logic [1:0] MEAS_CODE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_CODE,
        ST_ARM  = ARM_CODE,
        ST_MEAS = MEAS_CODE
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 1000000;
    localparam int unsigned DEFAULT_TOL     = 0;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizes an asynchronous level into clk and derives single-cycle
// rise/fall strobes from the synchronized value and its one-cycle delay.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    input  logic rearm,
    output logic s,
    output logic rise,
    output logic fall
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_reg;
    logic              s_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sig_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign s = sync_reg[STAGES-1];

    // s_d is reloaded from s every cycle, so rearm only has to mask the edge
    // strobes while the meter is being armed: a level already high is never a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_d_reg <= 1'b0;
        else        s_d_reg <= s;
    end

    assign rise = s & ~s_d_reg & ~rearm;
    assign fall = ~s & s_d_reg & ~rearm;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow toggling signal in clk cycles,
// with a stability flag across consecutive periods and a no-edge timeout.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned TOL         = DEFAULT_TOL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             stable,
    output logic             timeout,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TOL_W     = WIDTH'(TOL);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic             have_prev_reg, have_prev_next;
    logic [WIDTH-1:0] period_reg, period_next;
    logic [WIDTH-1:0] high_reg, high_next;
    logic             valid_reg, valid_next;
    logic             stable_reg, stable_next;
    logic             timeout_reg, timeout_next;

    logic             rise;
    logic             fall;
    logic             sig_level_unused;
    logic             rearm;
    logic [WIDTH-1:0] diff;

    assign rearm = (state_reg == ST_IDLE);

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rearm  (rearm),
        .s      (sig_level_unused),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        diff = (cnt_reg >= prev_reg) ? (cnt_reg - prev_reg) : (prev_reg - cnt_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            prev_reg      <= '0;
            have_prev_reg <= 1'b0;
            period_reg    <= '0;
            high_reg      <= '0;
            valid_reg     <= 1'b0;
            stable_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hi_reg        <= hi_next;
            prev_reg      <= prev_next;
            have_prev_reg <= have_prev_next;
            period_reg    <= period_next;
            high_reg      <= high_next;
            valid_reg     <= valid_next;
            stable_reg    <= stable_next;
            timeout_reg   <= timeout_next;
        end
    end

    // Priority inside each state: disable, then rise, then timeout, then fall.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hi_next        = hi_reg;
        prev_next      = prev_reg;
        have_prev_next = have_prev_reg;
        period_next    = period_reg;
        high_next      = high_reg;
        valid_next     = 1'b0;
        stable_next    = stable_reg;
        timeout_next   = 1'b0;

        if (!en) begin
            state_next     = ST_IDLE;
            cnt_next       = '0;
            hi_next        = '0;
            stable_next    = 1'b0;
            have_prev_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_next   = '0;
                    state_next = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_next     = ST_MEAS;
                        cnt_next       = ONE_W;
                        have_prev_next = 1'b0;
                    end else if (cnt_reg == TIMEOUT_W) begin
                        timeout_next = 1'b1;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt_reg + ONE_W;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_next    = cnt_reg;
                        high_next      = hi_reg;
                        valid_next     = 1'b1;
                        // The first period after arming has nothing to compare against.
                        stable_next    = have_prev_reg && (diff <= TOL_W);
                        prev_next      = cnt_reg;
                        have_prev_next = 1'b1;
                        cnt_next       = ONE_W;
                    end else if (cnt_reg == TIMEOUT_W) begin
                        timeout_next = 1'b1;
                        stable_next  = 1'b0;
                        state_next   = ST_ARM;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt_reg + ONE_W;
                        if (fall) hi_next = cnt_reg;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign period       = period_reg;
    assign high_time    = high_reg;
    assign period_valid = valid_reg;
    assign stable       = stable_reg;
    assign timeout      = timeout_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: stimulus pushes expected
// measurements and timeout cycles; a negedge monitor pops and compares.
module tb_clock_period_meter;

    localparam int WIDTH = 16;
    localparam int LAT   = 3;   // sig_in change to registered output, in cycles

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             stable;
    logic             timeout;
    logic             busy;

    always #5 clk = ~clk;

    clock_period_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .TIMEOUT     (50),
        .TOL         (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .stable       (stable),
        .timeout      (timeout),
        .busy         (busy)
    );

    typedef struct {
        int p;
        int h;
        int st;
        int cyc;
    } meas_t;

    meas_t exp_q[$];
    int    to_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of its queue.
    always @(negedge clk) begin : monitor
        meas_t m;
        int    t;
        if (rst_n) begin
            if (period_valid) begin
                $display("cycle %0d: period=%0d high_time=%0d stable=%0d",
                         cyc, period, high_time, stable);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    m = exp_q.pop_front();
                    check("period", int'(period), m.p);
                    check("high_time", int'(high_time), m.h);
                    check("stable", int'(stable), m.st);
                    check("valid_cycle", cyc, m.cyc);
                end
            end
            if (timeout) begin
                $display("cycle %0d: timeout", cyc);
                if (to_q.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    t = to_q.pop_front();
                    check("timeout_cycle", cyc, t);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l, input bit chk,
                         input int ep, input int eh, input int es);
        meas_t m;
        if (chk) begin
            m = '{ep, eh, es, cyc + LAT};
            exp_q.push_back(m);
        end
        sig_in = 1'b1;
        tick(h);
        sig_in = 1'b0;
        tick(l);
    endtask

    // Divider (5/5), asymmetric (3/9) and tolerance (10,11,10,13) sequence.
    // Each entry: high, low, check, expected period, high_time, stable.
    int tab_h [13] = '{5, 5, 5, 5, 5, 3, 3, 3, 3, 5, 5, 5, 5};
    int tab_l [13] = '{5, 5, 5, 5, 5, 9, 9, 9, 9, 5, 6, 5, 8};
    int tab_c [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int tab_p [13] = '{0, 10, 10, 10, 10, 10, 12, 12, 12, 12, 10, 11, 10};
    int tab_hi[13] = '{0, 5, 5, 5, 5, 5, 3, 3, 3, 3, 5, 5, 5};
    int tab_s [13] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};

    initial begin : stim
        int    x;
        meas_t m;

        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        tick(3);
        check("reset_period", int'(period), 0);
        check("reset_high_time", int'(high_time), 0);
        check("reset_valid", int'(period_valid), 0);
        check("reset_stable", int'(stable), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", int'(busy), 0);

        en = 1'b1;
        tick(3);
        check("arm_busy", int'(busy), 1);
        for (int i = 0; i < 13; i++)
            pulse(tab_h[i], tab_l[i], tab_c[i] != 0, tab_p[i], tab_hi[i], tab_s[i]);

        // Last rise, then stuck low: timeout 50 cycles after cnt=1, then every 51.
        x = cyc;
        m = '{13, 5, 0, x + LAT};
        exp_q.push_back(m);
        to_q.push_back(x + LAT + 50);
        to_q.push_back(x + LAT + 101);
        to_q.push_back(x + LAT + 152);
        sig_in = 1'b1;
        tick(5);
        sig_in = 1'b0;
        tick(165);
        check("timeout_period_hold", int'(period), 13);
        check("timeout_high_hold", int'(high_time), 5);
        check("timeout_stable", int'(stable), 0);
        check("timeout_busy", int'(busy), 1);

        // Enable with the signal already high: no measurement until a real 0->1.
        en = 1'b0;
        tick(1);
        check("disable_busy", int'(busy), 0);
        sig_in = 1'b1;
        tick(5);
        en = 1'b1;
        tick(10);
        check("armed_high_busy", int'(busy), 1);
        sig_in = 1'b0;
        tick(5);
        pulse(4, 4, 1'b0, 0, 0, 0);
        pulse(4, 4, 1'b1, 8, 4, 0);
        x = cyc;
        m = '{8, 4, 1, x + LAT};
        exp_q.push_back(m);
        sig_in = 1'b1;
        tick(4);
        sig_in = 1'b0;
        tick(2);
        en = 1'b0;
        tick(1);
        check("drop_en_busy", int'(busy), 0);
        check("drop_en_period", int'(period), 8);
        check("drop_en_high", int'(high_time), 4);
        check("drop_en_stable", int'(stable), 0);
        pulse(3, 3, 1'b0, 0, 0, 0);
        pulse(3, 3, 1'b0, 0, 0, 0);

        // Asynchronous reset in the middle of a MEAS period.
        en = 1'b1;
        tick(3);
        pulse(5, 5, 1'b0, 0, 0, 0);
        pulse(5, 5, 1'b1, 10, 5, 0);
        sig_in = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_period", int'(period), 0);
        check("async_rst_high", int'(high_time), 0);
        check("async_rst_valid", int'(period_valid), 0);
        check("async_rst_stable", int'(stable), 0);
        check("async_rst_timeout", int'(timeout), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        sig_in = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        pulse(6, 4, 1'b0, 0, 0, 0);
        pulse(6, 4, 1'b1, 10, 6, 0);
        pulse(6, 4, 1'b1, 10, 6, 1);
        tick(10);

        check("measurements_outstanding", exp_q.size(), 0);
        check("timeouts_outstanding", to_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
